bus_dev_endpoint: RTL and testbench

Device-side endpoint for the shared bus generator/arbiter (`bs_gnrtr_n_rbtr`): synthesizable RTL equivalent of one per-device bus FIFO agent. Buffers local transmit packets and presents them to the arbiter through `pndng`/`pop`/`D_pop`. Accepts arbiter deliveries on `push`/`D_push` into a receive FIFO drained by the local host. One instance per bus device; index `id` matches the device's arbiter port.

---
 rtl/bus_dev_endpoint.sv | 84 ++++++++
 tb/tb_bus_dev_endpoint.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dev_endpoint.sv
// rtl/bus_dev_endpoint.sv - per-device bus endpoint: TX FIFO toward the arbiter, RX FIFO from it
// Optional destination filter on deliveries: BUS_DEV_ADDR_FILTER_EN.
module bus_dev_endpoint #(
  parameter int           pckg_sz   = 16,
  parameter int           depth     = 8,
  parameter logic [7:0]   id        = 8'd0,
  parameter logic [7:0]   broadcast = 8'h8F
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_valid,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_ready,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_ready,
  output logic [7:0]         rx_drop_cnt,
  output logic               pop_err
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [aw:0]        tx_wr, tx_rd, rx_wr, rx_rd;
  logic               tx_empty, tx_full, rx_empty, rx_full;
  logic               tx_we, tx_re, rx_we, rx_re, rx_drop, addr_ok;

  // Equal pointers mean empty; equal index with differing wrap bit means full.
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[aw] != tx_rd[aw]) && (tx_wr[aw-1:0] == tx_rd[aw-1:0]);
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[aw] != rx_rd[aw]) && (rx_wr[aw-1:0] == rx_rd[aw-1:0]);

`ifdef BUS_DEV_ADDR_FILTER_EN
  assign addr_ok = (D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == broadcast);
`else
  assign addr_ok = 1'b1;
`endif

  assign tx_we   = tx_valid && !tx_full;
  assign tx_re   = pop && !tx_empty;
  assign rx_we   = push && addr_ok && !rx_full;
  assign rx_drop = push && !rx_we;
  assign rx_re   = rx_ready && !rx_empty;

  // Arbiter-facing outputs depend only on registered state, never on pop.
  assign tx_ready = !tx_full;
  assign pndng    = !tx_empty;
  assign D_pop    = tx_empty ? '0 : tx_mem[tx_rd[aw-1:0]];
  assign rx_valid = !rx_empty;
  assign rx_data  = rx_empty ? '0 : rx_mem[rx_rd[aw-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr       <= '0;
      tx_rd       <= '0;
      rx_wr       <= '0;
      rx_rd       <= '0;
      rx_drop_cnt <= 8'd0;
      pop_err     <= 1'b0;
    end else begin
      if (tx_we) tx_wr <= tx_wr + ptr_one;
      if (tx_re) tx_rd <= tx_rd + ptr_one;
      if (rx_we) rx_wr <= rx_wr + ptr_one;
      if (rx_re) rx_rd <= rx_rd + ptr_one;
      if (rx_drop && rx_drop_cnt != 8'hFF) rx_drop_cnt <= rx_drop_cnt + 8'd1;
      if (pop && tx_empty) pop_err <= 1'b1;
    end
  end

  // Storage needs no reset: empty FIFOs mask their contents.
  always_ff @(posedge clk) begin
    if (tx_we) tx_mem[tx_wr[aw-1:0]] <= tx_data;
    if (rx_we) rx_mem[rx_wr[aw-1:0]] <= D_push;
  end

endmodule

// File: tb/tb_bus_dev_endpoint.sv
// tb/tb_bus_dev_endpoint.sv - scoreboard bench for bus_dev_endpoint
module tb_bus_dev_endpoint;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tx_valid = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_ready;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop = 1'b0;
  logic        push = 1'b0;
  logic [15:0] D_push = '0;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_drop_cnt;
  logic        pop_err;

  int vectors = 0;
  int miscompares = 0;
  int exp_drop = 0;
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];

  bus_dev_endpoint #(.pckg_sz(16), .depth(8), .id(8'd3), .broadcast(8'h8F)) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_drop_cnt(rx_drop_cnt), .pop_err(pop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tx_valid = 0; pop = 0; push = 0; rx_ready = 0;
    reset = 0;
    tx_q.delete();
    rx_q.delete();
    exp_drop = 0;
    step();
    reset = 1;
    step();
  endtask

  // Monitor: every consuming handshake is checked against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (pop) begin
          if (tx_q.size() > 0) begin
            chk("pndng_at_pop", pndng, 1);
            chk("D_pop", D_pop, tx_q.pop_front());
          end else begin
            chk("pndng_empty_pop", pndng, 0);
            chk("D_pop_empty", D_pop, 0);
          end
        end
        if (rx_ready) begin
          if (rx_q.size() > 0) begin
            chk("rx_valid_at_read", rx_valid, 1);
            chk("rx_data", rx_data, rx_q.pop_front());
          end else begin
            chk("rx_valid_empty", rx_valid, 0);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] rx_vec [3];
    rx_vec[0] = 16'h0312; rx_vec[1] = 16'h8F34; rx_vec[2] = 16'h0556;

    do_reset();
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_pndng", pndng, 0);
    chk("rst_D_pop", D_pop, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_drop_cnt", rx_drop_cnt, 0);
    chk("rst_pop_err", pop_err, 0);

    // TX fill and drain
    for (int i = 1; i <= 8; i++) begin
      tx_valid = 1;
      tx_data = {i[7:0], i[7:0]};
      tx_q.push_back(tx_data);
      step();
      if (i == 1) chk("pndng_after_first", pndng, 1);
    end
    tx_valid = 0;
    chk("tx_ready_full", tx_ready, 0);
    chk("pndng_full", pndng, 1);
    for (int i = 0; i < 8; i++) begin
      pop = 1;
      step();
    end
    pop = 0;
    chk("pndng_drained", pndng, 0);
    chk("D_pop_drained", D_pop, 0);
    chk("tx_ready_drained", tx_ready, 1);

    // TX concurrent write/pop across pointer wrap
    for (int i = 1; i <= 3; i++) begin
      tx_valid = 1;
      tx_data = 16'hC000 + 16'(i);
      tx_q.push_back(tx_data);
      step();
    end
    for (int k = 0; k < 10; k++) begin
      tx_valid = 1;
      pop = 1;
      tx_data = 16'hD000 + 16'(k);
      tx_q.push_back(tx_data);
      step();
    end
    tx_valid = 0;
    pop = 0;
    chk("conc_tx_ready", tx_ready, 1);
    chk("conc_pop_err_clear", pop_err, 0);
    for (int i = 0; i < 3; i++) begin
      chk("conc_pndng_remaining", pndng, 1);
      pop = 1;
      step();
    end
    pop = 0;
    chk("conc_pndng_empty", pndng, 0);
    pop = 1;
    step();
    pop = 0;
    chk("pop_err_set", pop_err, 1);

    // RX address filter
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push = 1;
      D_push = rx_vec[i];
`ifdef BUS_DEV_ADDR_FILTER_EN
      if (i < 2) rx_q.push_back(rx_vec[i]); else exp_drop++;
`else
      rx_q.push_back(rx_vec[i]);
`endif
      step();
    end
    push = 0;
    chk("filter_drop_cnt", rx_drop_cnt, exp_drop);
    chk("filter_rx_valid", rx_valid, 1);
    chk("filter_head", rx_data, 16'h0312);
    for (int i = 0; i < 4; i++) begin
      rx_ready = 1;
      step();
    end
    rx_ready = 0;
    chk("filter_rx_empty", rx_valid, 0);

    // RX overflow, then push with simultaneous read while full
    do_reset();
    for (int i = 0; i < 9; i++) begin
      push = 1;
      D_push = 16'h0300 + 16'(i);
      if (i < 8) rx_q.push_back(D_push); else exp_drop++;
      step();
    end
    push = 0;
    chk("ovf_drop_cnt1", rx_drop_cnt, 1);
    push = 1;
    D_push = 16'h03AA;
    rx_ready = 1;
    exp_drop++;
    step();
    push = 0;
    rx_ready = 0;
    chk("ovf_drop_cnt2", rx_drop_cnt, 2);
    chk("ovf_head_after_read", rx_data, 16'h0301);
    for (int i = 0; i < 7; i++) begin
      rx_ready = 1;
      step();
    end
    rx_ready = 0;
    chk("ovf_rx_empty", rx_valid, 0);

    // Asynchronous reset with both FIFOs half full
    do_reset();
    pop = 1;
    step();
    pop = 0;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1;
      tx_data = 16'hE000 + 16'(i);
      push = 1;
      D_push = 16'h0310 + 16'(i);
      step();
    end
    tx_valid = 0;
    push = 0;
    chk("pre_rst_pndng", pndng, 1);
    chk("pre_rst_rx_valid", rx_valid, 1);
    chk("pre_rst_pop_err", pop_err, 1);
    #2;
    reset = 0;
    #1;
    chk("async_rst_pndng", pndng, 0);
    chk("async_rst_D_pop", D_pop, 0);
    chk("async_rst_rx_valid", rx_valid, 0);
    chk("async_rst_rx_data", rx_data, 0);
    chk("async_rst_tx_ready", tx_ready, 1);
    chk("async_rst_pop_err", pop_err, 0);
    chk("async_rst_drop_cnt", rx_drop_cnt, 0);
    step();
    reset = 1;
    step();
    chk("post_rst_pndng", pndng, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
